// File: rtl/sm_mdu_pkg.sv
// sm_mdu_pkg: shared definitions for the schoolMIPS multiply/divide sequencer.
// Holds the default operand width, the FSM state codes, the op encoding used on
// the 'op' input, and the instruction decode constants sm_control uses to pick
// MUL/DIVU out of the instruction stream.
package sm_mdu_pkg;

  // Default operand width and the iteration counter width that covers it
  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = 6;

  // Sequencer states
  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_DONE = 2'd2
  } mduState_t;

  // Operation select as driven by decode
  typedef enum logic {
    MDU_OP_MUL  = 1'b0,
    MDU_OP_DIVU = 1'b1
  } mduOp_t;

  // Instruction decode constants: MUL lives in SPECIAL2, DIVU in SPECIAL
  localparam logic [5:0] C_SPEC  = 6'b000000;
  localparam logic [5:0] C_SPEC2 = 6'b011100;
  localparam logic [5:0] F_MUL   = 6'b000010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  // True when the opcode/funct pair is one of the instructions this engine runs
  function automatic logic mduIsInstr(input logic [5:0] opcode, input logic [5:0] funct);
    return ((opcode == C_SPEC2) && (funct == F_MUL)) ||
           ((opcode == C_SPEC)  && (funct == F_DIVU));
  endfunction

  // Maps a recognised instruction onto the 'op' encoding of the sequencer
  function automatic mduOp_t mduOpOf(input logic [5:0] opcode);
    return (opcode == C_SPEC2) ? MDU_OP_MUL : MDU_OP_DIVU;
  endfunction

endpackage

// File: rtl/sm_mdu_datapath.sv
// sm_mdu_datapath: iterative shift-add multiplier / restoring divider.
// A pair of WIDTH-bit working registers {workHi, workLo} forms the 2*WIDTH
// accumulator for MUL and the {remainder, quotient} pair for DIVU. The second
// operand (multiplicand or divisor) and the op are latched on load so operand
// changes on the bus while iterating have no effect. nextLo_o/nextHi_o expose the
// value the working registers take after the current iteration, which lets the
// sequencer capture the final result on the same edge that ends the last step.
module sm_mdu_datapath
  import sm_mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             iterate_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] srcA_i,
  input  logic [WIDTH-1:0] srcB_i,
  output logic [WIDTH-1:0] nextLo_o,
  output logic [WIDTH-1:0] nextHi_o
);

  logic [WIDTH-1:0] workHi_q, workHi_d;
  logic [WIDTH-1:0] workLo_q, workLo_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             op_q, op_d;

  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] mulHi, mulLo;
  logic [WIDTH:0]   remShift;
  logic [WIDTH-1:0] quoShift;
  logic             divFits;
  logic [WIDTH-1:0] divHi, divLo;
  logic [WIDTH-1:0] stepHi, stepLo;

  // One multiply step: conditionally add the multiplicand into the upper half,
  // then shift the whole accumulator right with the add carry entering the MSB
  always_comb begin
    mulSum = {1'b0, workHi_q} + (workLo_q[0] ? {1'b0, operand_q} : '0);
    mulHi  = mulSum[WIDTH:1];
    mulLo  = {mulSum[0], workLo_q[WIDTH-1:1]};
  end

  // One restoring-divide step: shift {rem,quo} left, try subtracting the divisor
  // from the widened remainder and keep the difference only if it did not borrow
  always_comb begin
    remShift = {workHi_q, workLo_q[WIDTH-1]};
    quoShift = {workLo_q[WIDTH-2:0], 1'b0};
    divFits  = (remShift >= {1'b0, operand_q});
    divHi    = remShift[WIDTH-1:0];
    divLo    = quoShift;
    if (divFits) begin
      divHi = WIDTH'(remShift - {1'b0, operand_q});
      divLo = quoShift | WIDTH'(1);
    end
  end

  // Select the step result for the latched op
  always_comb begin
    stepHi = (op_q == MDU_OP_DIVU) ? divHi : mulHi;
    stepLo = (op_q == MDU_OP_DIVU) ? divLo : mulLo;
  end

  // Working register next-state: load fresh operands, iterate, or hold
  always_comb begin
    workHi_d  = workHi_q;
    workLo_d  = workLo_q;
    operand_d = operand_q;
    op_d      = op_q;
    if (load_i) begin
      op_d     = op_i;
      workHi_d = '0;
      if (op_i == MDU_OP_DIVU) begin
        workLo_d  = srcA_i;
        operand_d = srcB_i;
      end else begin
        workLo_d  = srcB_i;
        operand_d = srcA_i;
      end
    end else if (iterate_i) begin
      workHi_d = stepHi;
      workLo_d = stepLo;
    end
  end

  // Working registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      workHi_q  <= '0;
      workLo_q  <= '0;
      operand_q <= '0;
      op_q      <= 1'b0;
    end else begin
      workHi_q  <= workHi_d;
      workLo_q  <= workLo_d;
      operand_q <= operand_d;
      op_q      <= op_d;
    end
  end

  assign nextHi_o = stepHi;
  assign nextLo_o = stepLo;

endmodule

// File: rtl/sm_mdu_seq.sv
// sm_mdu_seq: multi-cycle multiply/divide sequencer for the schoolMIPS core.
// Accepts a decoded MUL/DIVU, stalls the pipeline for WIDTH iterations of the
// datapath, then pulses done for one cycle with stall released so the CPU
// retires the instruction and writes the result that same cycle. DIVU by zero
// finishes immediately with all-ones quotient and the dividend as remainder.
// abort drops any operation back to IDLE without touching the visible results.
module sm_mdu_seq
  import sm_mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = MDU_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] srcA_i,
  input  logic [WIDTH-1:0] srcB_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             divZero_o,
  output logic [WIDTH-1:0] resultLo_o,
  output logic [WIDTH-1:0] resultHi_o
);

  mduState_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             divZero_q, divZero_d;
  logic [WIDTH-1:0] resultLo_q, resultLo_d;
  logic [WIDTH-1:0] resultHi_q, resultHi_d;

  logic             accept;
  logic             divByZero;
  logic             lastIter;
  logic             dpLoad;
  logic             dpIterate;
  logic [WIDTH-1:0] dpNextLo, dpNextHi;

  // Qualified events: a start taken in IDLE, its divide-by-zero shortcut, and
  // the final iteration (abort overrides both)
  always_comb begin
    accept    = (state_q == MDU_IDLE) && start_i && !abort_i;
    divByZero = accept && (op_i == MDU_OP_DIVU) && (srcB_i == '0);
    lastIter  = (state_q == MDU_RUN) && (cnt_q == CNT_W'(1)) && !abort_i;
  end

  // State register; busy is registered alongside so it mirrors the RUN state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MDU_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; abort wins over everything, start is ignored outside IDLE
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = MDU_IDLE;
    end else begin
      unique case (state_q)
        MDU_IDLE: begin
          if (accept) state_d = divByZero ? MDU_DONE : MDU_RUN;
        end
        MDU_RUN: begin
          if (cnt_q == CNT_W'(1)) state_d = MDU_DONE;
        end
        MDU_DONE: state_d = MDU_IDLE;
        default:  state_d = MDU_IDLE;
      endcase
    end
    busy_d = (state_d == MDU_RUN);
  end

  // Output decode: stall covers the accepting cycle and every RUN cycle but is
  // released in DONE so the instruction retires while done is high
  always_comb begin
    stall_o   = accept || (state_q == MDU_RUN);
    done_o    = (state_q == MDU_DONE);
    dpLoad    = accept;
    dpIterate = (state_q == MDU_RUN) && !abort_i;
  end

  // Iteration counter: loaded with WIDTH on accept, counts down while running
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = CNT_W'(WIDTH);
    end else if (dpIterate) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Visible results and divZero only change on an accepted start or on
  // completion, so an aborted run never exposes a partial value
  always_comb begin
    resultLo_d = resultLo_q;
    resultHi_d = resultHi_q;
    divZero_d  = divZero_q;
    if (accept) begin
      divZero_d = divByZero;
    end
    if (divByZero) begin
      resultLo_d = '1;
      resultHi_d = srcA_i;
    end else if (lastIter) begin
      resultLo_d = dpNextLo;
      resultHi_d = dpNextHi;
    end
  end

  // Counter, result and divZero registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      divZero_q  <= 1'b0;
      resultLo_q <= '0;
      resultHi_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      divZero_q  <= divZero_d;
      resultLo_q <= resultLo_d;
      resultHi_q <= resultHi_d;
    end
  end

  sm_mdu_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (dpLoad),
    .iterate_i (dpIterate),
    .op_i      (op_i),
    .srcA_i    (srcA_i),
    .srcB_i    (srcB_i),
    .nextLo_o  (dpNextLo),
    .nextHi_o  (dpNextHi)
  );

  assign busy_o     = busy_q;
  assign divZero_o  = divZero_q;
  assign resultLo_o = resultLo_q;
  assign resultHi_o = resultHi_q;

endmodule

// File: tb/tb_sm_mdu_seq.sv
// tb_sm_mdu_seq: self-checking bench for the multiply/divide sequencer.
// Expected results come from plain 64-bit arithmetic and the documented
// latency rule; inputs are driven and outputs sampled on the falling edge.
module tb_sm_mdu_seq;

  localparam int W = 32;
  localparam int LAT_RUN = W + 1;

  logic         clk, rst, start, op, abort;
  logic [W-1:0] srcA, srcB;
  logic         stall, busy, done, divZero;
  logic [W-1:0] resultLo, resultHi;

  int errors = 0;
  int checks = 0;
  logic stallSeen;

  sm_mdu_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .op_i       (op),
    .abort_i    (abort),
    .srcA_i     (srcA),
    .srcB_i     (srcB),
    .stall_o    (stall),
    .busy_o     (busy),
    .done_o     (done),
    .divZero_o  (divZero),
    .resultLo_o (resultLo),
    .resultHi_o (resultHi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {hi, lo} of the operation from plain arithmetic
  function automatic logic [2*W-1:0] refResult(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    if (o == 1'b0) begin
      p = (2*W)'(a) * (2*W)'(b);
      return p;
    end
    if (b == '0) return {a, {W{1'b1}}};
    return {a % b, a / b};
  endfunction

  function automatic int refLatency(input logic o, input logic [W-1:0] b);
    return (o == 1'b1 && b == '0) ? 1 : LAT_RUN;
  endfunction

  // Presents a one-cycle start from IDLE; ends at the falling edge of cycle k+1
  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; srcA = a; srcB = b; abort = 1'b0;
    #1 stallSeen = stall;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done, scrambling operands to prove they were latched
  task automatic waitDone(output int lat, output int gaps);
    lat = 1; gaps = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (stall !== 1'b1 || busy !== 1'b1) gaps++;
      srcA = $urandom; srcB = $urandom;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = 1'b0; abort = 1'b0; srcA = '0; srcB = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_ctrl: busy=%b done=%b stall=%b want 0 0 0", busy, done, stall); end
    checks++; if (divZero !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_divZero: got %b want 0", divZero); end
    checks++; if (resultLo !== '0 || resultHi !== '0) begin errors++;
      $display("[TB] FAIL reset_results: lo=%h hi=%h want 0 0", resultLo, resultHi); end
    @(negedge clk);
  endtask

  // Runs one operation from IDLE and checks timing and value against the model
  task automatic runAndCheck(input string name, input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, gaps;
    logic [2*W-1:0] exp;
    exp = refResult(o, a, b);
    issue(o, a, b);
    checks++; if (stallSeen !== 1'b1) begin errors++;
      $display("[TB] FAIL %s stall_at_start: got %b want 1", name, stallSeen); end
    waitDone(lat, gaps);
    checks++; if (lat !== refLatency(o, b)) begin errors++;
      $display("[TB] FAIL %s latency: got %0d want %0d", name, lat, refLatency(o, b)); end
    checks++; if (gaps !== 0) begin errors++;
      $display("[TB] FAIL %s stall_busy_gaps: got %0d want 0", name, gaps); end
    checks++; if (resultLo !== exp[W-1:0] || resultHi !== exp[2*W-1:W]) begin errors++;
      $display("[TB] FAIL %s result: lo=%h hi=%h want lo=%h hi=%h", name, resultLo, resultHi, exp[W-1:0], exp[2*W-1:W]); end
    checks++; if (divZero !== (o == 1'b1 && b == '0)) begin errors++;
      $display("[TB] FAIL %s divZero: got %b want %b", name, divZero, (o == 1'b1 && b == '0)); end
    checks++; if (stall !== 1'b0) begin errors++;
      $display("[TB] FAIL %s stall_in_done: got %b want 0", name, stall); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("[TB] FAIL %s after_done: done=%b busy=%b want 0 0", name, done, busy); end
  endtask

  task automatic test_mul;
    runAndCheck("mul_7x6", 1'b0, 32'd7, 32'd6);
    runAndCheck("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_divu;
    runAndCheck("divu_100_7", 1'b1, 32'd100, 32'd7);
    runAndCheck("divu_5_9", 1'b1, 32'd5, 32'd9);
    runAndCheck("divu_max_1", 1'b1, 32'hFFFF_FFFF, 32'd1);
  endtask

  task automatic test_divzero;
    int lat, gaps;
    runAndCheck("divu_by_zero", 1'b1, 32'h0000_1234, 32'd0);
    issue(1'b0, 32'd3, 32'd4);
    checks++; if (divZero !== 1'b0) begin errors++;
      $display("[TB] FAIL divZero_cleared_by_mul: got %b want 0", divZero); end
    waitDone(lat, gaps);
    checks++; if (resultLo !== 32'd12 || resultHi !== 32'd0) begin errors++;
      $display("[TB] FAIL mul_after_divzero: lo=%h hi=%h want c 0", resultLo, resultHi); end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int pulses;
    runAndCheck("mul_before_abort", 1'b0, 32'd7, 32'd6);
    issue(1'b0, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || stall !== 1'b0) begin errors++;
      $display("[TB] FAIL abort_to_idle: busy=%b stall=%b want 0 0", busy, stall); end
    pulses = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) pulses++; end
    checks++; if (pulses !== 0) begin errors++;
      $display("[TB] FAIL abort_no_done: got %0d pulses want 0", pulses); end
    checks++; if (resultLo !== 32'd42 || resultHi !== 32'd0) begin errors++;
      $display("[TB] FAIL abort_results_kept: lo=%h hi=%h want 2a 0", resultLo, resultHi); end
    start = 1'b1; abort = 1'b1; op = 1'b0; srcA = 32'd2; srcB = 32'd2;
    #1;
    checks++; if (stall !== 1'b0) begin errors++;
      $display("[TB] FAIL start_abort_stall: got %b want 0", stall); end
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("[TB] FAIL start_abort_ignored: busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_start_held;
    int pulses, cyc;
    start = 1'b1; op = 1'b0; srcA = 32'd9; srcB = 32'd11; abort = 1'b0;
    pulses = 0; cyc = 0;
    while (pulses == 0 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (done === 1'b1) pulses++;
    end
    checks++; if (cyc !== LAT_RUN) begin errors++;
      $display("[TB] FAIL held_latency: got %0d want %0d", cyc, LAT_RUN); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++;
      $display("[TB] FAIL held_start_in_done: busy=%b want 0", busy); end
    start = 1'b0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) pulses++; end
    checks++; if (pulses !== 1) begin errors++;
      $display("[TB] FAIL held_single_done: got %0d pulses want 1", pulses); end
    checks++; if (resultLo !== 32'd99 || resultHi !== 32'd0) begin errors++;
      $display("[TB] FAIL held_result: lo=%h hi=%h want 63 0", resultLo, resultHi); end
  endtask

  task automatic test_reset_mid_run;
    issue(1'b1, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin errors++;
      $display("[TB] FAIL rst_mid_run_ctrl: busy=%b done=%b stall=%b want 0 0 0", busy, done, stall); end
    checks++; if (resultLo !== '0 || resultHi !== '0 || divZero !== 1'b0) begin errors++;
      $display("[TB] FAIL rst_mid_run_results: lo=%h hi=%h dz=%b want 0 0 0", resultLo, resultHi, divZero); end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic         o;
    logic [W-1:0] a, b;
    for (int i = 0; i < 16; i++) begin
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = a;
        default: b = $urandom;
      endcase
      runAndCheck($sformatf("random_%0d", i), o, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_divu();
    test_divzero();
    test_abort();
    test_start_held();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
